// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding and counter sizing for the bit-serial adder.
//   state_e : controller states (IDLE, ADD, DONE); encoding 2'd3 is illegal
//   cnt_w() : bit-cycle counter width for a given operand width (minimum 1)
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: single combinational full-adder cell.
//   X, Y, Z : addend bits and carry-in
//   S       : sum bit
//   C       : carry-out (majority of X, Y, Z)
module fa_cell (
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic S,
    output logic C
);

    assign S = X ^ Y ^ Z;
    assign C = (X & Y) | (X & Z) | (Y & Z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one shared full-adder cell stepped LSB first over WIDTH cycles.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : new-addition request, accepted in IDLE or DONE
//   A, B, CIN    : operands and carry-in, captured on an accepted start
//   busy         : high while bits are being added
//   done         : one-cycle pulse when SUM/COUT carry a fresh result
//   SUM, COUT    : registered result, held stable until the next DONE
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s, c;
    logic [WIDTH:0]   sh_ext;

    fa_cell u_fa (
        .X (a_q[0]),
        .Y (b_q[0]),
        .Z (carry_q),
        .S (s),
        .C (c)
    );

    // New sum bit enters at the MSB; the top WIDTH bits are the shifted result
    // (written this way so WIDTH = 1 needs no special-case slice).
    assign sh_ext = {s, sh_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? ADD : IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = sh_ext[WIDTH:1];
                carry_d = c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sh_ext[WIDTH:1];
                    cout_d  = c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign SUM  = sum_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl at WIDTH = 8 and WIDTH = 1.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       st1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    int         nvec = 0, nerr = 0;
    logic [8:0] last8 = '0;
    logic [1:0] last1 = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .CIN(cin8),
        .busy(busy8), .done(done8), .SUM(sum8), .COUT(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .CIN(cin1),
        .busy(busy1), .done(done1), .SUM(sum1), .COUT(cout1)
    );

    task automatic test_reset();
        @(negedge clk);
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++; $display("FAIL reset_w8: got busy=%b done=%b res=%h, want all 0", busy8, done8, {cout8, sum8});
        end
        nvec++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            nerr++; $display("FAIL reset_w1: got busy=%b done=%b res=%h, want all 0", busy1, done1, {cout1, sum1});
        end
        rst_n = 1'b1;
    endtask

    // Single addition on the 8-bit DUT with cycle-exact handshake checks.
    // ignore_at: ADD cycle in which a spurious start with other operands is pulsed (0 = none).
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input int ignore_at, input string nm);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; st8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            st8 = (k == ignore_at);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            nvec++;
            if ({busy8, done8} !== 2'b10 || {cout8, sum8} !== last8) begin
                nerr++; $display("FAIL %s_add_cycle%0d: got busy=%b done=%b res=%h, want busy=1 done=0 res=%h", nm, k, busy8, done8, {cout8, sum8}, last8);
            end
        end
        st8 = 1'b0;
        @(negedge clk);
        nvec++;
        if ({busy8, done8} !== 2'b01 || {cout8, sum8} !== exp) begin
            nerr++; $display("FAIL %s_done: got busy=%b done=%b res=%h, want busy=0 done=1 res=%h", nm, busy8, done8, {cout8, sum8}, exp);
        end
        last8 = exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            nvec++;
            if ({busy8, done8} !== 2'b00 || {cout8, sum8} !== last8) begin
                nerr++; $display("FAIL %s_idle%0d: got busy=%b done=%b res=%h, want busy=0 done=0 res=%h", nm, k, busy8, done8, {cout8, sum8}, last8);
            end
        end
    endtask

    task automatic test_directed();
        add8(8'h00, 8'h00, 1'b0, 0, "zero");
        add8(8'hFF, 8'h01, 1'b0, 0, "ff_plus_1");
        add8(8'hA5, 8'h5A, 1'b1, 0, "a5_5a_c");
        add8(8'h3C, 8'h42, 1'b0, 0, "3c_42");
        add8(8'hFF, 8'hFF, 1'b1, 0, "max");
    endtask

    task automatic test_random();
        repeat (20) add8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [2];
        logic [7:0] op  [4];
        op[0] = 8'h12; op[1] = 8'h34; op[2] = 8'h80; op[3] = 8'h80;
        exp[0] = 9'h046; exp[1] = 9'h100;
        @(negedge clk);
        a8 = op[0]; b8 = op[1]; cin8 = 1'b0; st8 = 1'b1;
        for (int j = 0; j < 2; j++) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                nvec++;
                if ({busy8, done8} !== 2'b10 || {cout8, sum8} !== last8) begin
                    nerr++; $display("FAIL b2b%0d_add_cycle%0d: got busy=%b done=%b res=%h, want busy=1 done=0 res=%h", j, k, busy8, done8, {cout8, sum8}, last8);
                end
            end
            @(negedge clk);
            nvec++;
            if ({busy8, done8} !== 2'b01 || {cout8, sum8} !== exp[j]) begin
                nerr++; $display("FAIL b2b%0d_done: got busy=%b done=%b res=%h, want busy=0 done=1 res=%h", j, busy8, done8, {cout8, sum8}, exp[j]);
            end
            last8 = exp[j];
            a8 = op[2]; b8 = op[3]; cin8 = 1'b0;
            st8 = (j == 0);
        end
        @(negedge clk);
        nvec++;
        if ({busy8, done8} !== 2'b00 || {cout8, sum8} !== last8) begin
            nerr++; $display("FAIL b2b_idle: got busy=%b done=%b res=%h, want busy=0 done=0 res=%h", busy8, done8, {cout8, sum8}, last8);
        end
    endtask

    task automatic test_ignored_start();
        add8(8'h11, 8'h22, 1'b0, 3, "ign");
        add8(8'h9C, 8'h71, 1'b1, 3, "ign2");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({busy8, done8} !== 2'b10) begin
            nerr++; $display("FAIL rstmid_pre: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++; $display("FAIL rstmid_async: got busy=%b done=%b res=%h, want all 0", busy8, done8, {cout8, sum8});
        end
        last8 = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++; $display("FAIL rstmid_held: got busy=%b done=%b res=%h, want all 0", busy8, done8, {cout8, sum8});
        end
        rst_n = 1'b1;
        add8(8'hC8, 8'h64, 1'b1, 0, "post_rst");
    endtask

    task automatic add1(input logic a, input logic b, input logic c, input string nm);
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        nvec++;
        if ({busy1, done1} !== 2'b10 || {cout1, sum1} !== last1) begin
            nerr++; $display("FAIL %s_w1_add: got busy=%b done=%b res=%b, want busy=1 done=0 res=%b", nm, busy1, done1, {cout1, sum1}, last1);
        end
        @(negedge clk);
        nvec++;
        if ({busy1, done1} !== 2'b01 || {cout1, sum1} !== exp) begin
            nerr++; $display("FAIL %s_w1_done: got busy=%b done=%b res=%b, want busy=0 done=1 res=%b", nm, busy1, done1, {cout1, sum1}, exp);
        end
        last1 = exp;
        @(negedge clk);
        nvec++;
        if ({busy1, done1} !== 2'b00 || {cout1, sum1} !== last1) begin
            nerr++; $display("FAIL %s_w1_idle: got busy=%b done=%b res=%b, want busy=0 done=0 res=%b", nm, busy1, done1, {cout1, sum1}, last1);
        end
    endtask

    task automatic test_width1();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            add1(v[2], v[1], v[0], "tt");
        end
        repeat (8) add1(1'($urandom), 1'($urandom), 1'($urandom), "rand");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
